mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one memory port between the Core101 instruction-fetch interface and data interface.
- Sits between the core and a unified memory.
- Accepts valid/ready requests from both sides and grants one at a time using round-robin.
- Forwards the granted request to memory and returns read data and ready to the granted requester.

Parameters:
- XLEN, 32, address and data width.
- TIMEOUT_CYCLES, 255, memory-wait cycles before abort; used only with MEM_ARB_TIMEOUT_EN; range 1..65535.

Ports:
- clock_in  in  1  system clock, all state on rising edge
- reset_in  in  1  asynchronous, active-high reset
- ins_req_valid_in  in  1  fetch request valid
- ins_req_addr_in  in  XLEN  fetch address
- ins_req_ready_out  out  1  one-cycle completion pulse to fetch
- ins_req_data_out  out  XLEN  fetched word, valid while ins_req_ready_out=1
- data_req_valid_in  in  1  load/store request valid
- data_req_write_in  in  1  1=store, 0=load
- data_req_addr_in  in  XLEN  data address
- data_req_wdata_in  in  XLEN  store data
- data_req_ready_out  out  1  one-cycle completion pulse to data side
- data_req_rdata_out  out  XLEN  load data, valid while data_req_ready_out=1
- mem_valid_out  out  1  request to memory
- mem_write_out  out  1  write strobe to memory
- mem_addr_out  out  XLEN  memory address
- mem_data_out  out  XLEN  memory write data
- mem_data_in  in  XLEN  memory read data
- mem_ready_in  in  1  memory completion, sampled while mem_valid_out=1
- timeout_err_out  out  1  one-cycle abort pulse; tied 0 without macro

Behaviour:
- Reset:
  - Asserting reset_in at any time forces IDLE.
  - All outputs go to 0 and last_grant=DATA, so fetch wins the first tie.
  - An in-flight memory transaction is abandoned; no ready pulse is issued for it.
- FSM states: IDLE, BUSY_INS, BUSY_DATA, RESP.
- IDLE:
  - With no valid input, stay in IDLE.
  - With exactly one valid, grant that requester.
  - With both valid, grant the one not equal to last_grant.
  - On grant, register addr, wdata and write (write forced 0 for fetch) into the mem_* output registers.
  - Set mem_valid_out=1 next cycle, update last_grant, and go to BUSY_INS or BUSY_DATA.
- BUSY_x:
  - mem_* outputs stay stable while mem_ready_in=0.
  - When mem_ready_in=1: capture mem_data_in into the granted requester's data output, clear mem_valid_out and mem_write_out, go to RESP.
  - For a store, the captured data is don't-care but is still driven from mem_data_in.
- RESP: the granted requester's ready_out=1 for exactly this cycle, then return to IDLE.
- Requester inputs are not sampled in RESP.
- A valid still high in IDLE is treated as a new request.
- Requesters must hold valid and fields stable until their ready pulse.
- Minimum latency: 3 cycles (grant, memory with zero wait, resp).
- Throughput: one transaction per 3 cycles at best. No pipelining, no outstanding requests.
- Non-granted requester: its ready stays 0 and its request keeps waiting.
- Round-robin alternation guarantees each side is served within 2 transactions.
- ready_out pulses are mutually exclusive.
- The data outputs of the non-granted side hold their previous value.
- Outputs are cleared to 0 only by reset.
- mem_ready_in while mem_valid_out=0 is ignored.
- No arithmetic beyond the timeout counter; addresses pass through unmodified, full XLEN.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on entering BUSY_x and increments each BUSY cycle with mem_ready_in=0.
  - When the count reaches TIMEOUT_CYCLES, mem_valid_out drops, the requester's data output is set to 0, and the FSM goes to RESP.
  - In RESP, the requester gets its ready pulse and timeout_err_out=1 for that RESP cycle.
  - If mem_ready_in=1 in the same cycle the limit is reached, the normal completion wins and there is no error.
- Undefined: no counter; BUSY waits indefinitely; timeout_err_out is constant 0.

Decomposition:
- Package core101_mem_pkg:
  - FSM state typedef (2-bit).
  - Grant enum {GRANT_INS, GRANT_DATA}.
  - Default TIMEOUT_CYCLES constant.
- Sub-module rr_arb2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: grant onehot, grant_valid.
- The FSM and datapath registers stay in the top.

Test Plan:
- Single fetch: ins valid, addr 0x0000_0010, mem ready on the first BUSY cycle with data 0x0000_0013 -> mem_valid_out high for 1 cycle with addr 0x10 and write=0; ins_req_ready_out pulses 3 cycles after valid with data 0x13.
- Store: data valid, write=1, addr 0x100, wdata 0xDEAD_BEEF, memory waits 4 cycles -> mem_write_out=1 and mem_data_out=0xDEADBEEF held stable 5 cycles; data_req_ready_out pulses once.
- Contention: both valid continuously out of reset -> grants in order INS, DATA, INS, DATA; ready pulses never overlap.
- Back-to-back: ins valid held through its ready pulse -> second fetch granted in the following IDLE cycle; the requester sees exactly two pulses.
- Reset mid-BUSY_DATA: assert reset_in asynchronously -> all outputs 0 immediately; after release, a pending ins plus data request grants INS first.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_ready_in never asserts -> after 8 BUSY cycles, ready pulse with data 0 and timeout_err_out=1; a repeat with ready asserted on cycle 8 -> normal completion, no error.

Source files
------------

// File: rtl/core101_mem_pkg.sv
// Shared types for the Core101 memory port arbiter.
// FSM state, grant identity and default abort limit.
package core101_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BUSY_INS  = 2'd1,
    S_BUSY_DATA = 2'd2,
    S_RESP      = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_INS  = 1'b0,
    GRANT_DATA = 1'b1
  } grant_e;

  localparam int TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; bit 0 is fetch, bit 1 is data.
// On a tie the side that was not served last wins.
module rr_arb2
  import core101_mem_pkg::*;
(
  input  logic [1:0] req,
  input  grant_e     last_grant,
  output logic [1:0] grant,
  output logic       grant_valid
);

  always_comb begin
    grant = 2'b00;
    priority case (1'b1)
      (req == 2'b11):
        grant = (last_grant == GRANT_DATA) ? 2'b01 : 2'b10;
      req[0]: grant = 2'b01;
      req[1]: grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign grant_valid = |req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between Core101 fetch and data sides.
// Optional memory-wait abort: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import core101_mem_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic            clock_in,
  input  logic            reset_in,
  input  logic            ins_req_valid_in,
  input  logic [XLEN-1:0] ins_req_addr_in,
  output logic            ins_req_ready_out,
  output logic [XLEN-1:0] ins_req_data_out,
  input  logic            data_req_valid_in,
  input  logic            data_req_write_in,
  input  logic [XLEN-1:0] data_req_addr_in,
  input  logic [XLEN-1:0] data_req_wdata_in,
  output logic            data_req_ready_out,
  output logic [XLEN-1:0] data_req_rdata_out,
  output logic            mem_valid_out,
  output logic            mem_write_out,
  output logic [XLEN-1:0] mem_addr_out,
  output logic [XLEN-1:0] mem_data_out,
  input  logic [XLEN-1:0] mem_data_in,
  input  logic            mem_ready_in,
  output logic            timeout_err_out
);

  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  grant_e          last_q, last_d;
  logic            mv_q, mv_d;
  logic            mw_q, mw_d;
  logic [XLEN-1:0] ma_q, ma_d;
  logic [XLEN-1:0] md_q, md_d;
  logic            irdy_q, irdy_d;
  logic [XLEN-1:0] idat_q, idat_d;
  logic            drdy_q, drdy_d;
  logic [XLEN-1:0] ddat_q, ddat_d;
  logic            tmo_q, tmo_d;
  logic [1:0]      gnt;
  logic            gnt_v;
  logic            expired;
  logic [XLEN-1:0] rdata;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_LIM;
`endif

  rr_arb2 u_rr (
    .req         ({data_req_valid_in, ins_req_valid_in}),
    .last_grant  (last_q),
    .grant       (gnt),
    .grant_valid (gnt_v)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    mv_d    = mv_q;
    mw_d    = mw_q;
    ma_d    = ma_q;
    md_d    = md_q;
    idat_d  = idat_q;
    ddat_d  = ddat_q;
    irdy_d  = 1'b0;
    drdy_d  = 1'b0;
    tmo_d   = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    expired = !mem_ready_in && (cnt_q == TMO_LIM);
`else
    expired = 1'b0;
`endif
    rdata = expired ? '0 : mem_data_in;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_v) begin
          state_d = gnt[1] ? S_BUSY_DATA : S_BUSY_INS;
          last_d  = gnt[1] ? GRANT_DATA : GRANT_INS;
          mv_d    = 1'b1;
          mw_d    = gnt[1] & data_req_write_in;
          ma_d    = gnt[1] ? data_req_addr_in
                           : ins_req_addr_in;
          if (gnt[1]) md_d = data_req_wdata_in;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      S_BUSY_INS, S_BUSY_DATA: begin
        if (mem_ready_in || expired) begin
          state_d = S_RESP;
          mv_d    = 1'b0;
          mw_d    = 1'b0;
          tmo_d   = expired;
          if (state_q == S_BUSY_INS) begin
            idat_d = rdata;
            irdy_d = 1'b1;
          end else begin
            ddat_d = rdata;
            drdy_d = 1'b1;
          end
        end else begin
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d = cnt_q + 16'd1;
`endif
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      last_q  <= GRANT_DATA;
      mv_q    <= 1'b0;
      mw_q    <= 1'b0;
      ma_q    <= '0;
      md_q    <= '0;
      irdy_q  <= 1'b0;
      idat_q  <= '0;
      drdy_q  <= 1'b0;
      ddat_q  <= '0;
      tmo_q   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      mv_q    <= mv_d;
      mw_q    <= mw_d;
      ma_q    <= ma_d;
      md_q    <= md_d;
      irdy_q  <= irdy_d;
      idat_q  <= idat_d;
      drdy_q  <= drdy_d;
      ddat_q  <= ddat_d;
      tmo_q   <= tmo_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign ins_req_ready_out  = irdy_q;
  assign ins_req_data_out   = idat_q;
  assign data_req_ready_out = drdy_q;
  assign data_req_rdata_out = ddat_q;
  assign mem_valid_out      = mv_q;
  assign mem_write_out      = mw_q;
  assign mem_addr_out       = ma_q;
  assign mem_data_out       = md_q;
  assign timeout_err_out    = tmo_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a
// transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int XLEN = 32;
  localparam int TO   = 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic            clock_in = 1'b0;
  logic            reset_in;
  logic            ins_req_valid_in;
  logic [XLEN-1:0] ins_req_addr_in;
  logic            ins_req_ready_out;
  logic [XLEN-1:0] ins_req_data_out;
  logic            data_req_valid_in;
  logic            data_req_write_in;
  logic [XLEN-1:0] data_req_addr_in;
  logic [XLEN-1:0] data_req_wdata_in;
  logic            data_req_ready_out;
  logic [XLEN-1:0] data_req_rdata_out;
  logic            mem_valid_out;
  logic            mem_write_out;
  logic [XLEN-1:0] mem_addr_out;
  logic [XLEN-1:0] mem_data_out;
  logic [XLEN-1:0] mem_data_in;
  logic            mem_ready_in;
  logic            timeout_err_out;

  mem_port_arbiter #(
    .XLEN           (XLEN),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock_in           (clock_in),
    .reset_in           (reset_in),
    .ins_req_valid_in   (ins_req_valid_in),
    .ins_req_addr_in    (ins_req_addr_in),
    .ins_req_ready_out  (ins_req_ready_out),
    .ins_req_data_out   (ins_req_data_out),
    .data_req_valid_in  (data_req_valid_in),
    .data_req_write_in  (data_req_write_in),
    .data_req_addr_in   (data_req_addr_in),
    .data_req_wdata_in  (data_req_wdata_in),
    .data_req_ready_out (data_req_ready_out),
    .data_req_rdata_out (data_req_rdata_out),
    .mem_valid_out      (mem_valid_out),
    .mem_write_out      (mem_write_out),
    .mem_addr_out       (mem_addr_out),
    .mem_data_out       (mem_data_out),
    .mem_data_in        (mem_data_in),
    .mem_ready_in       (mem_ready_in),
    .timeout_err_out    (timeout_err_out)
  );

  always #5 clock_in = ~clock_in;

  int nchk = 0;
  int nerr = 0;

  // reference model: transaction phase and expected outputs
  int         m_phase;
  bit         m_last_data;
  bit         m_side;
  int         m_wait;
  int         m_delay;
  bit         e_irdy, e_drdy, e_mv, e_mw, e_tmo;
  logic [31:0] e_idat, e_ddat, e_ma, e_md;

  int          ins_mode, dat_mode, dly_mode;
  bit          use_fix;
  logic [31:0] fix_rdata;
  bit          pulses[$];
  int          n_ins_pulse;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_last_data = 1'b1;
    m_wait = 0; m_delay = 0; m_side = 1'b0;
    e_irdy = 0; e_drdy = 0; e_mv = 0; e_mw = 0;
    e_tmo = 0; e_idat = 0; e_ddat = 0;
    e_ma = 0; e_md = 0;
  endtask

  task automatic model_update(input bit rdy,
                              input logic [31:0] d);
    bit done, abort;
    e_irdy = 0; e_drdy = 0; e_tmo = 0;
    if (m_phase == 0) begin
      if (ins_req_valid_in || data_req_valid_in) begin
        if (ins_req_valid_in && data_req_valid_in)
          m_side = !m_last_data;
        else
          m_side = data_req_valid_in;
        m_last_data = m_side;
        e_mv = 1;
        e_ma = m_side ? data_req_addr_in : ins_req_addr_in;
        e_mw = m_side && data_req_write_in;
        if (m_side) e_md = data_req_wdata_in;
        m_wait = 0;
        m_delay = (dly_mode < 0) ? $urandom_range(0, 10)
                                 : dly_mode;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      done  = rdy;
      abort = !rdy && TMO_EN && (m_wait + 1 == TO);
      if (done || abort) begin
        e_mv = 0; e_mw = 0; e_tmo = abort;
        if (m_side) begin
          e_drdy = 1; e_ddat = abort ? 32'h0 : d;
        end else begin
          e_irdy = 1; e_idat = abort ? 32'h0 : d;
        end
        m_phase = 2;
      end else begin
        m_wait++;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic check_all();
    check("ins_rdy", ins_req_ready_out, e_irdy);
    check("ins_data", ins_req_data_out, e_idat);
    check("dat_rdy", data_req_ready_out, e_drdy);
    check("dat_data", data_req_rdata_out, e_ddat);
    check("mem_valid", mem_valid_out, e_mv);
    check("mem_write", mem_write_out, e_mw);
    check("mem_addr", mem_addr_out, e_ma);
    check("mem_wdata", mem_data_out, e_md);
    check("tmo_err", timeout_err_out, e_tmo);
    check("rdy_excl",
          ins_req_ready_out & data_req_ready_out, 0);
  endtask

  task automatic drive_reqs();
    if (!ins_req_valid_in || e_irdy) begin
      ins_req_valid_in = (ins_mode == 2) ||
        (ins_mode == 1 && $urandom_range(0, 2) != 0);
      if (ins_req_valid_in) ins_req_addr_in = $urandom;
    end
    if (!data_req_valid_in || e_drdy) begin
      data_req_valid_in = (dat_mode == 2) ||
        (dat_mode == 1 && $urandom_range(0, 2) != 0);
      if (data_req_valid_in) begin
        data_req_addr_in  = $urandom;
        data_req_wdata_in = $urandom;
        data_req_write_in = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic step();
    bit rdy;
    logic [31:0] d;
    d = use_fix ? fix_rdata : $urandom;
    if (m_phase == 1) rdy = (m_wait == m_delay);
    else rdy = 1'($urandom_range(0, 1));
    mem_ready_in = rdy;
    mem_data_in  = d;
    model_update(rdy, d);
    @(posedge clock_in);
    @(negedge clock_in);
    check_all();
    if (ins_req_ready_out) begin
      pulses.push_back(1'b0); n_ins_pulse++;
    end
    if (data_req_ready_out) pulses.push_back(1'b1);
    drive_reqs();
  endtask

  task automatic drain();
    ins_mode = 0; dat_mode = 0;
    for (int i = 0; i < 200; i++) begin
      if (ins_req_valid_in || data_req_valid_in || m_phase != 0)
        step();
    end
    check("drain_idle",
          {31'd0, ins_req_valid_in || data_req_valid_in
                  || m_phase != 0}, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_irdy"}, ins_req_ready_out, 0);
    check({tag, "_idat"}, ins_req_data_out, 0);
    check({tag, "_drdy"}, data_req_ready_out, 0);
    check({tag, "_ddat"}, data_req_rdata_out, 0);
    check({tag, "_mv"}, mem_valid_out, 0);
    check({tag, "_mw"}, mem_write_out, 0);
    check({tag, "_ma"}, mem_addr_out, 0);
    check({tag, "_md"}, mem_data_out, 0);
    check({tag, "_tmo"}, timeout_err_out, 0);
  endtask

  initial begin
    logic [31:0] a0;
    reset_in = 1; ins_req_valid_in = 0; ins_req_addr_in = 0;
    data_req_valid_in = 0; data_req_write_in = 0;
    data_req_addr_in = 0; data_req_wdata_in = 0;
    mem_data_in = 0; mem_ready_in = 0;
    ins_mode = 0; dat_mode = 0; dly_mode = 0;
    use_fix = 0; fix_rdata = 0; n_ins_pulse = 0;
    model_reset();
    #1 check_zero("rst");
    @(negedge clock_in); @(negedge clock_in);
    reset_in = 0;

    // contention from reset: INS, DATA, INS, DATA
    ins_mode = 2; dat_mode = 2; dly_mode = -1;
    drive_reqs();
    for (int i = 0; i < 40; i++) step();
    check("cont_cnt", {31'd0, pulses.size() >= 4}, 1);
    for (int i = 0; i < 4 && i < pulses.size(); i++)
      check($sformatf("cont_ord%0d", i), pulses[i], i % 2);
    drain();

    // single fetch, zero wait
    use_fix = 1; fix_rdata = 32'h13; dly_mode = 0;
    ins_req_valid_in = 1; ins_req_addr_in = 32'h10;
    step();
    check("f_mv", mem_valid_out, 1);
    check("f_ma", mem_addr_out, 32'h10);
    check("f_mw", mem_write_out, 0);
    step();
    check("f_rdy", ins_req_ready_out, 1);
    check("f_dat", ins_req_data_out, 32'h13);
    check("f_mv0", mem_valid_out, 0);
    drain();

    // store with 4 wait cycles
    dly_mode = 4;
    data_req_valid_in = 1; data_req_write_in = 1;
    data_req_addr_in = 32'h100;
    data_req_wdata_in = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("s_mw", mem_write_out, 1);
      check("s_md", mem_data_out, 32'hDEAD_BEEF);
      check("s_rdy0", data_req_ready_out, 0);
    end
    step();
    check("s_rdy", data_req_ready_out, 1);
    drain();

    // back-to-back fetches
    dly_mode = 0; n_ins_pulse = 0;
    ins_mode = 2; ins_req_valid_in = 1;
    ins_req_addr_in = 32'h200;
    step(); step();
    a0 = ins_req_addr_in;
    ins_mode = 0;
    step(); step();
    check("b2b_gnt", mem_addr_out, a0);
    for (int i = 0; i < 4; i++) step();
    check("b2b_cnt", n_ins_pulse, 2);
    drain();

    // random traffic
    use_fix = 0; dly_mode = -1;
    ins_mode = 1; dat_mode = 1;
    for (int i = 0; i < 600; i++) step();
    drain();

    // async reset in the middle of a data transaction
    dly_mode = 10;
    data_req_valid_in = 1; data_req_write_in = 0;
    data_req_addr_in = 32'h300;
    for (int i = 0; i < 50; i++)
      if (!(m_phase == 1 && m_side)) step();
    check("busy_data", {31'd0, m_phase == 1 && m_side}, 1);
    #2 reset_in = 1;
    #1 check_zero("arst");
    @(posedge clock_in); @(negedge clock_in);
    reset_in = 0;
    model_reset();
    dly_mode = 1;
    ins_req_valid_in = 1; ins_req_addr_in = 32'h440;
    data_req_valid_in = 1; data_req_addr_in = 32'h880;
    step();
    check("rst_gnt", mem_addr_out, 32'h440);
    drain();

`ifdef MEM_ARB_TIMEOUT_EN
    use_fix = 1; fix_rdata = 32'h5555_AAAA;
    dly_mode = 99;
    ins_req_valid_in = 1; ins_req_addr_in = 32'h40;
    for (int i = 0; i < 8; i++) begin
      step();
      check("to_busy", mem_valid_out, 1);
    end
    step();
    check("to_rdy", ins_req_ready_out, 1);
    check("to_dat", ins_req_data_out, 0);
    check("to_err", timeout_err_out, 1);
    drain();
    dly_mode = 7;
    ins_req_valid_in = 1; ins_req_addr_in = 32'h44;
    for (int i = 0; i < 9; i++) step();
    check("lim_rdy", ins_req_ready_out, 1);
    check("lim_dat", ins_req_data_out, 32'h5555_AAAA);
    check("lim_err", timeout_err_out, 0);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
